// File: rtl/rf_bus_arbiter.sv
// Two-master round-robin arbiter in front of the register-file slave port.
// Grants are registered; a bounded hold counter forces a handover when both masters want the port.
module rf_bus_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DIN_W    = 32,
    parameter int DOUT_W   = 64,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DIN_W-1:0]  m0_din,
    output logic              m0_grant,
    output logic [DOUT_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DIN_W-1:0]  m1_din,
    output logic              m1_grant,
    output logic [DOUT_W-1:0] m1_dout,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DIN_W-1:0]  s_din,
    input  logic [DOUT_W-1:0] s_dout,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, G0, G1} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

    state_t           state, state_nx;
    logic             rr_ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic             at_lim;

    assign at_lim = (hold_cnt == HOLD_LIM);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (m0_req && m1_req) state_nx = rr_ptr ? G1 : G0;
                else if (m0_req)      state_nx = G0;
                else if (m1_req)      state_nx = G1;
            end
            G0: begin
                if (!m0_req)                state_nx = m1_req ? G1 : IDLE;
                else if (m1_req && at_lim)  state_nx = G1;
            end
            G1: begin
                if (!m1_req)                state_nx = m0_req ? G0 : IDLE;
                else if (m0_req && at_lim)  state_nx = G0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                hold_cnt <= '0;
                if (state_nx == G0) begin
                    rr_ptr <= 1'b1;
                    owner  <= 1'b0;
                end else if (state_nx == G1) begin
                    rr_ptr <= 1'b0;
                    owner  <= 1'b1;
                end
            end else if (state != IDLE && !at_lim) begin
                // Saturating: a lone master keeps the port indefinitely.
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign m0_grant = (state == G0);
    assign m1_grant = (state == G1);
    assign busy     = m0_grant | m1_grant;
    assign m0_dout  = s_dout;
    assign m1_dout  = s_dout;

    // Write strobe is gated by req so a dropped request never writes on its last granted cycle.
    always_comb begin
        s_wr   = 1'b0;
        s_addr = '0;
        s_din  = '0;
        case (state)
            G0: begin
                s_wr   = m0_wr & m0_req;
                s_addr = m0_addr;
                s_din  = m0_din;
            end
            G1: begin
                s_wr   = m1_wr & m1_req;
                s_addr = m1_addr;
                s_din  = m1_din;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_bus_arbiter.sv
// Directed bench for rf_bus_arbiter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_rf_bus_arbiter;

    localparam logic [31:0] D0 = 32'hA5A5_0001;
    localparam logic [31:0] D1 = 32'h5A5A_0002;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_din = D0, m1_din = D1;
    logic [63:0] sdout = 64'hDEAD_BEEF_0123_4567;
    logic        m0_grant, m1_grant, s_wr, busy, owner;
    logic [63:0] m0_dout, m1_dout;
    logic [15:0] s_addr;
    logic [31:0] s_din;

    typedef struct {
        int          id;
        int          tst;
        logic        g0, g1, swr, own;
        logic [15:0] addr;
        logic [31:0] din;
        logic [63:0] dout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   step_id = 0, tst = 0;
    logic done = 1'b0;

    rf_bus_arbiter #(.ADDR_W(16), .DIN_W(32), .DOUT_W(64), .MAX_HOLD(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_grant(m0_grant), .m0_dout(m0_dout),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_grant(m1_grant), .m1_dout(m1_dout),
        .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(sdout),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic step(input logic rs, input logic q0, input logic w0, input logic [15:0] a0,
                        input logic q1, input logic w1, input logic [15:0] a1,
                        input logic eg0, input logic eg1, input logic eswr,
                        input logic [15:0] ea, input logic eo);
        exp_t e;
        reset = rs; m0_req = q0; m0_wr = w0; m0_addr = a0;
        m1_req = q1; m1_wr = w1; m1_addr = a1;
        e.id = step_id; e.tst = tst;
        e.g0 = eg0; e.g1 = eg1; e.swr = eswr; e.addr = ea; e.own = eo;
        e.din = eg0 ? D0 : (eg1 ? D1 : 32'h0);
        e.dout = sdout;
        sb.push_back(e);
        step_id++;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (m0_grant && m1_grant) begin
                errors++;
                $display("FAIL mutex: both grants high at %0t", $time);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (m0_grant !== e.g0 || m1_grant !== e.g1 || s_wr !== e.swr || s_addr !== e.addr ||
                    s_din !== e.din || owner !== e.own || busy !== (e.g0 | e.g1) ||
                    m0_dout !== e.dout || m1_dout !== e.dout) begin
                    errors++;
                    $display("FAIL t%0d.s%0d: got g0=%b g1=%b busy=%b wr=%b addr=%h din=%h own=%b d0=%h d1=%h; want g0=%b g1=%b wr=%b addr=%h din=%h own=%b dout=%h",
                             e.tst, e.id, m0_grant, m1_grant, busy, s_wr, s_addr, s_din, owner, m0_dout, m1_dout,
                             e.g0, e.g1, e.swr, e.addr, e.din, e.own, e.dout);
                end
            end
            if (done) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left, want 0", sb.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        // reset state
        tst = 0;
        step(1, 0,0,16'h0, 0,0,16'h0, 0,0,0,16'h0,0);
        step(1, 0,0,16'h0, 0,0,16'h0, 0,0,0,16'h0,0);

        // single master write
        tst = 1;
        step(0, 1,1,16'h0005, 0,0,16'h0, 0,0,0,16'h0000,0);
        for (int i = 0; i < 3; i++)
            step(0, 1,1,16'h0005, 0,0,16'h0, 1,0,1,16'h0005,0);
        step(0, 0,1,16'h0005, 0,0,16'h0, 1,0,0,16'h0005,0);
        step(0, 0,0,16'h0005, 0,0,16'h0, 0,0,0,16'h0000,0);

        // simultaneous first request after reset
        tst = 2;
        step(1, 0,0,16'h0010, 0,0,16'h0020, 0,0,0,16'h0,0);
        step(0, 1,0,16'h0010, 1,0,16'h0020, 0,0,0,16'h0000,0);
        step(0, 1,0,16'h0010, 1,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 0,0,16'h0010, 1,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 0,0,16'h0010, 1,0,16'h0020, 0,1,0,16'h0020,1);
        step(0, 0,0,16'h0010, 0,0,16'h0020, 0,1,0,16'h0020,1);
        step(0, 0,0,16'h0010, 0,0,16'h0020, 0,0,0,16'h0000,1);

        // fairness: strict alternation
        tst = 3;
        step(0, 1,0,16'h0010, 1,0,16'h0020, 0,0,0,16'h0000,1);
        for (int r = 0; r < 8; r++) begin
            step(0, 0,0,16'h0010, 1,0,16'h0020, 1,0,0,16'h0010,0);
            step(0, 1,0,16'h0010, 0,0,16'h0020, 0,1,0,16'h0020,1);
        end
        step(0, 0,0,16'h0010, 0,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 0,0,16'h0010, 0,0,16'h0020, 0,0,0,16'h0000,0);

        // hold limit (MAX_HOLD=4), preemption both ways, saturation
        tst = 4;
        step(0, 1,0,16'h0010, 0,0,16'h0020, 0,0,0,16'h0000,0);
        for (int i = 0; i < 4; i++)
            step(0, 1,0,16'h0010, 1,0,16'h0020, 1,0,0,16'h0010,0);
        for (int i = 0; i < 4; i++)
            step(0, 1,0,16'h0010, 1,0,16'h0020, 0,1,0,16'h0020,1);
        for (int i = 0; i < 4; i++)
            step(0, 1,0,16'h0010, 0,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 1,0,16'h0010, 1,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 1,0,16'h0010, 0,0,16'h0020, 0,1,0,16'h0020,1);
        step(0, 0,0,16'h0010, 0,0,16'h0020, 1,0,0,16'h0010,0);
        step(0, 0,0,16'h0010, 0,0,16'h0020, 0,0,0,16'h0000,0);

        // read broadcast
        tst = 5;
        sdout = 64'h0000_0000_0000_0001;
        step(0, 0,0,16'h0010, 1,0,16'h0015, 0,0,0,16'h0000,0);
        step(0, 0,0,16'h0010, 1,0,16'h0015, 0,1,0,16'h0015,1);
        step(0, 0,0,16'h0010, 0,0,16'h0015, 0,1,0,16'h0015,1);
        step(0, 0,0,16'h0010, 0,0,16'h0015, 0,0,0,16'h0000,1);
        sdout = 64'hDEAD_BEEF_0123_4567;

        // reset in the middle of an m1 write
        tst = 6;
        step(0, 0,0,16'h0010, 1,1,16'h0033, 0,0,0,16'h0000,1);
        step(0, 0,0,16'h0010, 1,1,16'h0033, 0,1,1,16'h0033,1);
        step(1, 1,1,16'h0010, 1,1,16'h0033, 0,0,0,16'h0000,0);
        step(1, 1,1,16'h0010, 1,1,16'h0033, 0,0,0,16'h0000,0);
        step(0, 1,1,16'h0010, 1,1,16'h0033, 0,0,0,16'h0000,0);
        step(0, 1,1,16'h0010, 1,1,16'h0033, 1,0,1,16'h0010,0);
        step(0, 0,0,16'h0010, 0,0,16'h0033, 1,0,0,16'h0010,0);
        step(0, 0,0,16'h0010, 0,0,16'h0033, 0,0,0,16'h0000,0);

        done = 1'b1;
    end

endmodule

// File: doc/rf_bus_arbiter.md
Name: rf_bus_arbiter

Overview:
- Two-master, round-robin arbiter that shares the single register-file slave port (s_wr/s_addr/s_din/s_dout) between master 0 (host/testbench bus) and master 1 (internal engine).
- Registered grant with a bounded hold time (MAX_HOLD) so neither master can starve the other.
- Sits directly in front of the RF slave port. Read data is broadcast to both masters. interrupt_out passes through untouched and is outside this block.

Parameters:
- ADDR_W, 16, slave address width.
- DIN_W, 32, write-data width.
- DOUT_W, 64, read-data width.
- MAX_HOLD, 16, max consecutive grant cycles while the other master is waiting (≥2).
- CNT_W, 5, hold-counter width; must hold MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 bus request; held until transfer sequence done.
- m0_wr  in  1  master 0 write strobe (1=write, 0=read).
- m0_addr  in  ADDR_W  master 0 address.
- m0_din  in  DIN_W  master 0 write data.
- m0_grant  out  1  master 0 owns the port.
- m0_dout  out  DOUT_W  read data to master 0.
- m1_req, m1_wr, m1_addr, m1_din, m1_grant, m1_dout: same as master 0, for master 1.
- s_wr  out  1  to RF write strobe.
- s_addr  out  ADDR_W  to RF address.
- s_din  out  DIN_W  to RF write data.
- s_dout  in  DOUT_W  from RF read data.
- busy  out  1  some grant is active.
- owner  out  1  last/current owner (0=m0, 1=m1).

Behaviour:
- Reset (async, active-high): state=IDLE, m0_grant=0, m1_grant=0, busy=0, owner=0, rr_ptr=0 (m0 favoured), hold_cnt=0. s_wr=0, s_addr=0, s_din=0 follow combinationally from IDLE.
- States: IDLE, G0 (m0 granted), G1 (m1 granted). Grants are registered: a request first seen at edge n gives grant high after edge n, so it is visible in cycle n+1.
- IDLE transitions:
  - Only m0_req → G0.
  - Only m1_req → G1.
  - Both requesting → master selected by rr_ptr.
  - Neither → stay IDLE.
- G0 transitions (G1 is symmetric):
  - m0_req=0 and m1_req=1 → G1, with no idle bubble.
  - m0_req=0 and m1_req=0 → IDLE.
  - m0_req=1, m1_req=1 and hold_cnt==MAX_HOLD-1 → G1 (forced preemption).
  - Otherwise stay in G0.
- On every entry to G0, rr_ptr←1 and owner←0. On every entry to G1, rr_ptr←0 and owner←1. owner keeps its value in IDLE.
- hold_cnt:
  - Cleared to 0 on any grant entry and in IDLE.
  - Increments each cycle the grant is held.
  - Saturates at MAX_HOLD-1 when the other master is idle; the grant then persists indefinitely.
- Slave mux (combinational):
  - In Gx: s_addr=mx_addr, s_din=mx_din, s_wr = mx_wr & mx_req.
  - In IDLE: all three outputs are 0.
  - Gating s_wr with mx_req prevents a spurious write in the cycle after a master drops its request.
- Read path: m0_dout = m1_dout = s_dout at all times. A master samples data only while its grant is high, with the same timing as a direct RF read.
- Preempted master: its grant drops after the switch edge; it must keep req high and wait for re-grant. A write it presents in the switch cycle is not issued.
- Mutual exclusion: m0_grant & m1_grant is never 1. busy = m0_grant | m1_grant.
- Reset mid-transfer: grant drops immediately (async) and s_wr goes to 0 in the same cycle; no partial write is issued after reset asserts.
- Requests arriving while reset is high are ignored. Arbitration restarts at the first clk edge after deassertion, with rr_ptr=0.

Test Plan:
- Single master: m0_req=1, m0_wr=1, m0_addr=16'h0005, m0_din=32'hA5A5_0001 held 3 cycles. Required: m0_grant=1 from cycle 2; s_wr=1 with s_addr=16'h0005; m1_grant=0 throughout; after m0_req drops → IDLE, s_wr=0 next cycle.
- Simultaneous first request: m0_req=m1_req=1 right after reset. Required: m0 granted first; after m0_req drops, m1_grant=1 on the next cycle with no idle cycle; owner goes 0→1.
- Fairness: both masters issue alternating single-cycle-gap requests for 8 rounds. Required: grants strictly alternate m0,m1,m0,…; m0_grant&m1_grant never 1.
- Hold limit: MAX_HOLD=4, m0_req held continuously, m1_req asserted at cycle 2. Required: m0_grant high for exactly 4 cycles, then m1_grant=1; m0 re-granted only after m1_req drops or m1 hits 4 cycles.
- Read broadcast: m1 read at s_addr=16'h0015 while the RF returns 64'h0000_0000_0000_0001. Required: s_wr=0; m1_dout=m0_dout=64'h1 during the grant.
- Reset mid-write: assert reset while in G1 with m1_wr=1. Required: m1_grant=0 and s_wr=0 in the same cycle; after release with m0_req=m1_req=1, m0 granted first.
